// File: rtl/seg_scan_controller_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// segment table, digit-select one-hots and FSM state encodings.
package seg_scan_controller_pkg;

    localparam logic DISPLAY = 1'b0;
    localparam logic BLANK   = 1'b1;

    localparam logic [3:0] DIG0 = 4'b0001;
    localparam logic [3:0] DIG1 = 4'b0010;
    localparam logic [3:0] DIG2 = 4'b0100;
    localparam logic [3:0] DIG3 = 4'b1000;

    // gfedcba, active-high, indexed by hex value
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] dig_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = DIG0;
            2'd1:    sel = DIG1;
            2'd2:    sel = DIG2;
            2'd3:    sel = DIG3;
            default: sel = DIG0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// CPU-side write/latch port plus the display pin bundle of the scan controller.
interface seg_scan_controller_if;

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       latch_req;
    logic       latch_ack;
    logic       lz_en;
    logic [7:0] seg_out;
    logic [3:0] dig_sel;
    logic       frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, wr_dp, latch_req, lz_en,
        input  latch_ack, seg_out, dig_sel, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_dp, latch_req, lz_en,
        output latch_ack, seg_out, dig_sel, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to gfedcba segment pattern (active-high).
module seg_hex_decode
    import seg_scan_controller_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit seven-segment scanner with shadow/live buffers
// committed only at frame boundaries, leading-zero suppression and decimal points.
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter logic [31:0] DWELL_CYCLES = 32'd8250,
    parameter logic [31:0] BLANK_CYCLES = 32'd33,
    parameter logic        ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    seg_scan_controller_if.slave  bus
);

    logic             state_r;
    logic             state_s;
    logic [31:0]      cnt_r;
    logic [31:0]      cnt_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic             boundary_s;

    logic [3:0][3:0]  shadow_val_r;
    logic [3:0]       shadow_dp_r;
    logic [3:0][3:0]  live_val_r;
    logic [3:0]       live_dp_r;
    logic             pending_r;
    logic             latch_ack_r;
    logic             frame_done_r;

    logic [6:0]       hex_seg_s;
    logic             blank_s;
    logic [7:0]       seg_next_s;
    logic [3:0]       dig_next_s;
    logic [7:0]       seg_r;
    logic [3:0]       dig_r;

    seg_hex_decode u_hex_decode (
        .hex (live_val_r[idx_r]),
        .seg (hex_seg_s)
    );

    // Scan FSM state register: phase, dwell/blank counter and digit index
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= DISPLAY;
            cnt_r   <= 32'd0;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
        end
    end

    // Scan FSM next-state logic; boundary_s marks the cycle idx wraps 3->0
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + 32'd1;
        idx_s      = idx_r;
        boundary_s = 1'b0;
        case (state_r)
            DISPLAY: begin
                if (cnt_r == (DWELL_CYCLES - 32'd1)) begin
                    cnt_s = 32'd0;
                    if (BLANK_CYCLES == 32'd0) begin
                        idx_s      = idx_r + 2'd1;
                        boundary_s = (idx_r == 2'd3);
                    end else begin
                        state_s = BLANK;
                    end
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            BLANK: begin
                if (cnt_r == (BLANK_CYCLES - 32'd1)) begin
                    cnt_s      = 32'd0;
                    state_s    = DISPLAY;
                    idx_s      = idx_r + 2'd1;
                    boundary_s = (idx_r == 2'd3);
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = DISPLAY;
                cnt_s   = 32'd0;
                idx_s   = 2'd0;
            end
        endcase
    end

    // Shadow writes, pending latch tracking and boundary commit to live
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shadow_val_r <= 16'h0000;
            shadow_dp_r  <= 4'b0000;
            live_val_r   <= 16'h0000;
            live_dp_r    <= 4'b0000;
            pending_r    <= 1'b0;
            latch_ack_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                shadow_val_r[bus.wr_addr] <= bus.wr_data;
                shadow_dp_r[bus.wr_addr]  <= bus.wr_dp;
            end
            // A request in the boundary cycle is held for the following frame
            if (boundary_s) begin
                pending_r <= bus.latch_req;
                if (pending_r) begin
                    live_val_r <= shadow_val_r;
                    live_dp_r  <= shadow_dp_r;
                end
            end else begin
                pending_r <= pending_r | bus.latch_req;
            end
            latch_ack_r  <= boundary_s & pending_r;
            frame_done_r <= boundary_s;
        end
    end

    // Leading-zero suppression: blank digit idx when it and every higher digit is 0 with no dp
    always_comb begin
        blank_s = 1'b0;
        if (bus.lz_en && (idx_r != 2'd0)) begin
            blank_s = 1'b1;
            for (int k = 0; k < 4; k++) begin
                blank_s = blank_s & ~((k >= int'(idx_r)) &
                          ((live_val_r[k[1:0]] != 4'd0) | live_dp_r[k[1:0]]));
            end
        end else begin
            blank_s = 1'b0;
        end
    end

    // Scan FSM output logic: active-high pin values for the current phase
    always_comb begin
        dig_next_s = 4'b0000;
        seg_next_s = 8'h00;
        if (state_r == DISPLAY) begin
            dig_next_s = dig_onehot(idx_r);
            seg_next_s = blank_s ? 8'h00 : {live_dp_r[idx_r], hex_seg_s};
        end else begin
            dig_next_s = 4'b0000;
            seg_next_s = 8'h00;
        end
    end

    // Pin registers with board polarity applied
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            seg_r <= {8{ACTIVE_LOW}};
            dig_r <= {4{ACTIVE_LOW}};
        end else begin
            seg_r <= seg_next_s ^ {8{ACTIVE_LOW}};
            dig_r <= dig_next_s ^ {4{ACTIVE_LOW}};
        end
    end

    assign bus.seg_out    = seg_r;
    assign bus.dig_sel    = dig_r;
    assign bus.latch_ack  = latch_ack_r;
    assign bus.frame_done = frame_done_r;

endmodule
